id_stage: RTL and testbench

- Instruction-decode stage; sits directly downstream of instruction fetch. Consumes the fetched instruction `Ins` and `nextPC`.
- Latches both into an IF/ID register with stall and flush.
- Holds the 32x32 register file, which is written by the write-back stage.
- Decodes control for a MIPS subset.
- Produces branch/jump targets and a redirect request; these feed fetch's `newPC` path.

---
 rtl/id_stage.sv | 150 +++++++++++++++
 tb/tb_id_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS-subset decode stage: IF/ID latch, register file, control decode, branch/jump resolution
// Optional: define ID_RF_BYPASS_EN for write-through bypass of write-back data onto Rdata1/Rdata2.
module id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Ins,
  input  logic [31:0] nextPC,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        W_RWE,
  input  logic [4:0]  W_RA,
  input  logic [31:0] W_RD,
  output logic [31:0] Rdata1,
  output logic [31:0] Rdata2,
  output logic [31:0] Imm32,
  output logic [4:0]  Shamt,
  output logic [4:0]  Wreg,
  output logic [3:0]  ALUCtl,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        Redirect,
  output logic [31:0] TargetPC,
  output logic [31:0] LinkPC,
  output logic        Illegal
);

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                         OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E,
                         OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;

  logic [31:0] ir, pcd;
  logic [31:0] gpr [32];

  always_ff @(posedge CLK) begin
    if (RST || Flush) begin
      ir  <= 32'h0;
      pcd <= RESET_PC;
    end else if (!Stall) begin
      ir  <= Ins;
      pcd <= nextPC;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) gpr[i] <= 32'h0;
    end else if (W_RWE && (W_RA != 5'd0)) begin
      gpr[W_RA] <= W_RD;
    end
  end

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic [25:0] idx;
  assign op  = ir[31:26];
  assign rs  = ir[25:21];
  assign rt  = ir[20:16];
  assign rd  = ir[15:11];
  assign fn  = ir[5:0];
  assign imm = ir[15:0];
  assign idx = ir[25:0];

`ifdef ID_RF_BYPASS_EN
  logic byp_en;
  assign byp_en = W_RWE && (W_RA != 5'd0);
  assign Rdata1 = (byp_en && W_RA == rs) ? W_RD : gpr[rs];
  assign Rdata2 = (byp_en && W_RA == rt) ? W_RD : gpr[rt];
`else
  assign Rdata1 = gpr[rs];
  assign Rdata2 = gpr[rt];
`endif

  assign Shamt  = ir[10:6];
  assign LinkPC = pcd;
  assign Wreg   = (op == OP_R) ? rd : (op == OP_JAL) ? 5'd31 : rt;

  logic [31:0] imm_sext, br_target;
  logic        reg_wr;
  assign imm_sext  = {{16{imm[15]}}, imm};
  assign br_target = pcd + {imm_sext[29:0], 2'b00};

  // Unknown encodings fall to the defaults, so Illegal naturally leaves every side effect at 0.
  always_comb begin
    Imm32    = imm_sext;
    ALUCtl   = 4'd0;
    ALUSrc   = 1'b0;
    reg_wr   = 1'b0;
    MemWrite = 1'b0;
    MemToReg = 1'b0;
    Redirect = 1'b0;
    TargetPC = pcd;
    Illegal  = 1'b0;
    if (ir != 32'h0) begin
      unique case (op)
        OP_R: begin
          reg_wr = 1'b1;
          unique case (fn)
            6'h20, 6'h21: ALUCtl = 4'd0;
            6'h22, 6'h23: ALUCtl = 4'd1;
            6'h24:        ALUCtl = 4'd2;
            6'h25:        ALUCtl = 4'd3;
            6'h26:        ALUCtl = 4'd4;
            6'h27:        ALUCtl = 4'd5;
            6'h2A:        ALUCtl = 4'd6;
            6'h2B:        ALUCtl = 4'd7;
            6'h00:        ALUCtl = 4'd8;
            6'h02:        ALUCtl = 4'd9;
            6'h03:        ALUCtl = 4'd10;
            6'h08: begin
              reg_wr   = 1'b0;
              Redirect = 1'b1;
              TargetPC = Rdata1;
            end
            default: begin
              reg_wr  = 1'b0;
              Illegal = 1'b1;
            end
          endcase
        end
        OP_ADDI, OP_ADDIU: begin ALUSrc = 1'b1; reg_wr = 1'b1; end
        OP_SLTI:  begin ALUSrc = 1'b1; reg_wr = 1'b1; ALUCtl = 4'd6; end
        OP_SLTIU: begin ALUSrc = 1'b1; reg_wr = 1'b1; ALUCtl = 4'd7; end
        OP_ANDI:  begin ALUSrc = 1'b1; reg_wr = 1'b1; ALUCtl = 4'd2; Imm32 = {16'h0, imm}; end
        OP_ORI:   begin ALUSrc = 1'b1; reg_wr = 1'b1; ALUCtl = 4'd3; Imm32 = {16'h0, imm}; end
        OP_XORI:  begin ALUSrc = 1'b1; reg_wr = 1'b1; ALUCtl = 4'd4; Imm32 = {16'h0, imm}; end
        OP_LUI:   begin ALUSrc = 1'b1; reg_wr = 1'b1; ALUCtl = 4'd11; Imm32 = {imm, 16'h0}; end
        OP_LW:    begin ALUSrc = 1'b1; reg_wr = 1'b1; MemToReg = 1'b1; end
        OP_SW:    begin ALUSrc = 1'b1; MemWrite = 1'b1; end
        OP_BEQ:   begin ALUCtl = 4'd1; TargetPC = br_target; Redirect = (Rdata1 == Rdata2); end
        OP_BNE:   begin ALUCtl = 4'd1; TargetPC = br_target; Redirect = (Rdata1 != Rdata2); end
        OP_J:     begin Redirect = 1'b1; TargetPC = {pcd[31:28], idx, 2'b00}; end
        OP_JAL: begin
          reg_wr   = 1'b1;
          Redirect = 1'b1;
          TargetPC = {pcd[31:28], idx, 2'b00};
        end
        default: Illegal = 1'b1;
      endcase
    end
  end

  assign RegWrite = reg_wr && (Wreg != 5'd0);

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed-vector self-checking bench for id_stage
module tb_id_stage;
  logic        CLK = 1'b0, RST, Stall, Flush, W_RWE;
  logic [31:0] Ins, nextPC, W_RD;
  logic [4:0]  W_RA;
  logic [31:0] Rdata1, Rdata2, Imm32, TargetPC, LinkPC;
  logic [4:0]  Shamt, Wreg;
  logic [3:0]  ALUCtl;
  logic        ALUSrc, RegWrite, MemWrite, MemToReg, Redirect, Illegal;
  int total = 0, bad = 0;

  id_stage dut (
    .CLK(CLK), .RST(RST), .Ins(Ins), .nextPC(nextPC), .Stall(Stall), .Flush(Flush),
    .W_RWE(W_RWE), .W_RA(W_RA), .W_RD(W_RD), .Rdata1(Rdata1), .Rdata2(Rdata2),
    .Imm32(Imm32), .Shamt(Shamt), .Wreg(Wreg), .ALUCtl(ALUCtl), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .MemToReg(MemToReg), .Redirect(Redirect),
    .TargetPC(TargetPC), .LinkPC(LinkPC), .Illegal(Illegal)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    W_RWE = 1'b1; W_RA = a; W_RD = d;
    Stall = 1'b1;
    tick();
    W_RWE = 1'b0; Stall = 1'b0;
  endtask

  initial begin
    RST = 1'b1; Stall = 1'b0; Flush = 1'b0; W_RWE = 1'b0; W_RA = 5'd0; W_RD = 32'h0;
    Ins = 32'h2008_0005; nextPC = 32'h0000_0004;
    tick(); tick();
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_wreg", Wreg, 0);
    chk("rst_imm", Imm32, 0);
    chk("rst_aluctl", ALUCtl, 0);
    chk("rst_alusrc", ALUSrc, 0);
    chk("rst_redirect", Redirect, 0);
    chk("rst_target", TargetPC, 0);
    chk("rst_link", LinkPC, 0);
    chk("rst_illegal", Illegal, 0);

    RST = 1'b0;
    tick();
    chk("addi_regwrite", RegWrite, 1);
    chk("addi_wreg", Wreg, 8);
    chk("addi_imm", Imm32, 5);
    chk("addi_alusrc", ALUSrc, 1);
    chk("addi_aluctl", ALUCtl, 0);

    W_RWE = 1'b1; W_RA = 5'd9; W_RD = 32'hDEAD_BEEF; Ins = 32'h212A_0000;
    tick();
    W_RWE = 1'b0; #1;
    chk("gpr9_read", Rdata1, 32'hDEAD_BEEF);

    W_RWE = 1'b1; W_RA = 5'd0; W_RD = 32'h1; Ins = 32'h200A_0000;
    tick();
    chk("r0_bypass_guard", Rdata1, 0);
    W_RWE = 1'b0; #1;
    chk("r0_read", Rdata1, 0);

    wr(5'd8, 32'd7);
    wr(5'd9, 32'd7);
    Ins = 32'h1109_FFFF; nextPC = 32'h0000_0010;
    tick();
    chk("beq_taken", Redirect, 1);
    chk("beq_target", TargetPC, 32'h0000_000C);
    chk("beq_aluctl", ALUCtl, 1);
    chk("beq_regwrite", RegWrite, 0);
    wr(5'd9, 32'd6);
    #1;
    chk("beq_not_taken", Redirect, 0);

    Ins = 32'h1509_0002; nextPC = 32'h0000_0020;
    tick();
    chk("bne_taken", Redirect, 1);
    chk("bne_target", TargetPC, 32'h0000_0028);

    Ins = 32'h0C10_0000; nextPC = 32'h0040_0004;
    tick();
    chk("jal_target", TargetPC, 32'h0040_0000);
    chk("jal_wreg", Wreg, 31);
    chk("jal_link", LinkPC, 32'h0040_0004);
    chk("jal_regwrite", RegWrite, 1);
    chk("jal_redirect", Redirect, 1);

    Ins = 32'h0120_0008;
    tick();
    chk("jr_redirect", Redirect, 1);
    chk("jr_target", TargetPC, 32'd6);
    chk("jr_regwrite", RegWrite, 0);

    Ins = 32'h3C0A_1234;
    tick();
    chk("lui_imm", Imm32, 32'h1234_0000);
    chk("lui_aluctl", ALUCtl, 11);
    Ins = 32'h3508_8000;
    tick();
    chk("ori_zext", Imm32, 32'h0000_8000);
    chk("ori_aluctl", ALUCtl, 3);
    Ins = 32'h2108_8000;
    tick();
    chk("addi_sext", Imm32, 32'hFFFF_8000);

    Ins = 32'h0022_1822;
    tick();
    chk("sub_aluctl", ALUCtl, 1);
    chk("sub_wreg", Wreg, 3);
    chk("sub_regwrite", RegWrite, 1);
    chk("sub_alusrc", ALUSrc, 0);
    Ins = 32'h0002_2143;
    tick();
    chk("sra_aluctl", ALUCtl, 10);
    chk("sra_shamt", Shamt, 5);
    Ins = 32'h0022_1801;
    tick();
    chk("badfn_illegal", Illegal, 1);
    chk("badfn_regwrite", RegWrite, 0);

    Ins = 32'hAD09_0008;
    tick();
    chk("sw_memwrite", MemWrite, 1);
    chk("sw_regwrite", RegWrite, 0);
    chk("sw_alusrc", ALUSrc, 1);

    Ins = 32'h8D09_0004;
    tick();
    chk("lw_memtoreg", MemToReg, 1);
    chk("lw_wreg", Wreg, 9);
    Stall = 1'b1; Ins = 32'h0022_1822;
    tick();
    chk("stall_memtoreg", MemToReg, 1);
    chk("stall_imm", Imm32, 4);
    Flush = 1'b1;
    tick();
    chk("flush_memtoreg", MemToReg, 0);
    chk("flush_regwrite", RegWrite, 0);
    chk("flush_imm", Imm32, 0);
    chk("flush_link", LinkPC, 0);
    Stall = 1'b0; Flush = 1'b0;

    Ins = 32'h2109_0000;
    tick();
    W_RWE = 1'b1; W_RA = 5'd8; W_RD = 32'd3; Stall = 1'b1; #1;
`ifdef ID_RF_BYPASS_EN
    chk("bypass_rdata1", Rdata1, 3);
`else
    chk("bypass_rdata1", Rdata1, 7);
`endif
    tick();
    W_RWE = 1'b0; Stall = 1'b0; #1;
    chk("post_write_rdata1", Rdata1, 3);

    Ins = 32'hFC00_0000;
    tick();
    chk("ill_illegal", Illegal, 1);
    chk("ill_regwrite", RegWrite, 0);
    chk("ill_redirect", Redirect, 0);
    chk("ill_memwrite", MemWrite, 0);

    W_RWE = 1'b1; W_RA = 5'd5; W_RD = 32'h55; RST = 1'b1;
    tick(); tick();
    RST = 1'b0; W_RWE = 1'b0;
    for (int i = 0; i < 32; i++) begin
      Ins = {6'h0, i[4:0], i[4:0], 16'h0};
      tick();
      chk($sformatf("gpr%0d_rs", i), Rdata1, 0);
      chk($sformatf("gpr%0d_rt", i), Rdata2, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
